// File: rtl/softmc_app_pkg.sv
// Shared constants for the SoftMC MC-side responder.
//   INSTR_W     : instruction word width
//   OPC_MSB/LSB : opcode field position inside an instruction
//   OPC_END     : opcode that terminates a batch
//   RDBK_BEATS  : DRAM beats per readback word
package softmc_app_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 28;
    localparam int RDBK_BEATS = 4;

    localparam logic [OPC_MSB-OPC_LSB:0] OPC_END = 4'hF;

    function automatic logic is_end(input logic [INSTR_W-1:0] w);
        return w[OPC_MSB:OPC_LSB] == OPC_END;
    endfunction

endpackage

// File: rtl/softmc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   wr_en/wr_data : push, ignored while full (full is the pre-pop state)
//   rd_en         : pop, ignored while empty
//   rd_data       : current head, valid whenever empty is low
//   count/full/empty : occupancy, all derived from registered state
// DEPTH must be a power of two so the pointers wrap naturally.
module softmc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push;
    logic pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/softmc_mc_responder.sv
// MC-side SoftMC responder: batches host instructions and owns the readback FIFO.
//   app_en/app_instr/app_ack : instruction intake, accepted the cycle app_ack is high
//   instr_valid/instr_ready/instr_data : instruction release to the sequencer
//   rd_wr_en/rd_wr_data/rd_full : readback words arriving from the PHY side
//   rdback_fifo_empty/rdback_fifo_rden/rdback_data : FWFT readback to the host side
//   busy, instr_overflow, rd_drop : status (the latter two sticky until reset)
//
// Handshakes: a transfer happens on a rising clk edge where the offering side
// holds valid (app_en, instr_valid, rd_wr_en) and the other side is able to
// take it (app_ack, instr_ready, ~rd_full); the offer and its data stay stable
// until that edge.
module softmc_mc_responder
    import softmc_app_pkg::*;
#(
    parameter int DQ_WIDTH    = 64,
    parameter int INSTR_DEPTH = 16,
    parameter int RDBK_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         app_en,
    output logic                         app_ack,
    input  logic [INSTR_W-1:0]           app_instr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_W-1:0]           instr_data,
    input  logic                         rd_wr_en,
    input  logic [DQ_WIDTH*RDBK_BEATS-1:0] rd_wr_data,
    output logic                         rd_full,
    output logic                         rdback_fifo_empty,
    input  logic                         rdback_fifo_rden,
    output logic [DQ_WIDTH*RDBK_BEATS-1:0] rdback_data,
    output logic                         busy,
    output logic                         instr_overflow,
    output logic                         rd_drop
);

    localparam int RD_W     = DQ_WIDTH * RDBK_BEATS;
    localparam int BP_W     = $clog2(INSTR_DEPTH) + 1;
    localparam int RD_CNT_W = $clog2(RDBK_DEPTH) + 1;

    logic                instr_full;
    logic                instr_empty;
    logic [BP_W-1:0]     instr_count;
    logic                instr_pop;
    logic [RD_CNT_W-1:0] rd_count;

    logic [BP_W-1:0] batches_pending_q, batches_pending_d;
    logic            force_release_q,   force_release_d;
    logic            instr_overflow_q,  instr_overflow_d;
    logic            rd_drop_q,         rd_drop_d;

    logic acc_end;
    logic pop_end;
    logic set_force;

    // rst_n is folded in so no ack can escape while the FIFO is held in reset.
    assign app_ack     = rst_n & app_en & ~instr_full;
    assign instr_valid = ~instr_empty & ((batches_pending_q != '0) | force_release_q);
    assign instr_pop   = instr_valid & instr_ready;

    assign acc_end   = app_ack & is_end(app_instr);
    assign pop_end   = instr_pop & is_end(instr_data);
    // A full FIFO with no END inside can never release on its own.
    assign set_force = instr_full & (batches_pending_q == '0);

    softmc_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (INSTR_DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (app_ack),
        .wr_data (app_instr),
        .rd_en   (instr_pop),
        .rd_data (instr_data),
        .count   (instr_count),
        .full    (instr_full),
        .empty   (instr_empty)
    );

    softmc_sync_fifo #(
        .WIDTH (RD_W),
        .DEPTH (RDBK_DEPTH)
    ) u_rdbk_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rd_wr_en),
        .wr_data (rd_wr_data),
        .rd_en   (rdback_fifo_rden),
        .rd_data (rdback_data),
        .count   (rd_count),
        .full    (rd_full),
        .empty   (rdback_fifo_empty)
    );

    always_comb begin
        batches_pending_d = batches_pending_q;
        if (acc_end && !pop_end) begin
            batches_pending_d = batches_pending_q + BP_W'(1);
        end else if (!acc_end && pop_end && (batches_pending_q != '0)) begin
            batches_pending_d = batches_pending_q - BP_W'(1);
        end

        force_release_d = force_release_q;
        if (set_force) begin
            force_release_d = 1'b1;
        end else if (instr_empty) begin
            force_release_d = 1'b0;
        end

        instr_overflow_d = instr_overflow_q | set_force;
        // Capacity is judged before any same-cycle pop, matching the FIFO's own gating.
        rd_drop_d = rd_drop_q | (rd_wr_en & (rd_count == RD_CNT_W'(RDBK_DEPTH)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batches_pending_q <= '0;
            force_release_q   <= 1'b0;
            instr_overflow_q  <= 1'b0;
            rd_drop_q         <= 1'b0;
        end else begin
            batches_pending_q <= batches_pending_d;
            force_release_q   <= force_release_d;
            instr_overflow_q  <= instr_overflow_d;
            rd_drop_q         <= rd_drop_d;
        end
    end

    assign busy           = (instr_count != '0) | (batches_pending_q != '0);
    assign instr_overflow = instr_overflow_q;
    assign rd_drop        = rd_drop_q;

endmodule
